// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, reset PC and FSM state type for the fetch stage
package instr_fetch_pkg;
  localparam int ADDR_W  = 19;
  localparam int INSTR_W = 19;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 19'h00000;

  typedef enum logic [1:0] {RST, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/instr_fetch_pc_reg.sv
// rtl/instr_fetch_pc_reg.sv - program counter with redirect mux and wrapping +1 incrementer
module fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int            W        = ADDR_W,
  parameter logic [W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_redirect,
  input  logic [W-1:0] i_target,
  input  logic         i_incr,
  output logic [W-1:0] o_pc
);
  logic [W-1:0] r_pc;

  // Redirect wins over increment; the add wraps naturally at 2^W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= i_target;
    end else if (i_incr) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch FSM: one outstanding imem request, squash on redirect, decode handshake
module instr_fetch #(
  parameter int                   ADDR_W   = instr_fetch_pkg::ADDR_W,
  parameter int                   INSTR_W  = instr_fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = instr_fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i
);
  import instr_fetch_pkg::*;

  fetch_state_t       r_state;
  fetch_state_t       w_state_d;
  logic               r_squash;
  logic               w_squash_d;
  logic               r_valid;
  logic               w_valid_d;
  logic               r_req;
  logic               w_redirect;
  logic               w_incr;
  logic               w_capture;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [ADDR_W-1:0]  w_pc;

  fetch_pc_reg #(
    .W        (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_redirect (w_redirect),
    .i_target   (branch_target_i),
    .i_incr     (w_incr),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RST;
      r_squash   <= 1'b0;
      r_valid    <= 1'b0;
      r_req      <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state  <= w_state_d;
      r_squash <= w_squash_d;
      r_valid  <= w_valid_d;
      r_req    <= (w_state_d == REQ);
      if (w_capture) begin
        r_instr    <= imem_rsp_data_i;
        r_instr_pc <= w_pc;
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_squash_d = r_squash;
    w_valid_d  = r_valid;
    w_redirect = 1'b0;
    w_incr     = 1'b0;
    w_capture  = 1'b0;
    unique case (r_state)
      RST: w_state_d = REQ;
      REQ: begin
        w_state_d = WAIT;
        if (branch_taken_i) begin
          w_redirect = 1'b1;
          w_squash_d = 1'b1;
        end
      end
      WAIT: begin
        // A response in the redirect cycle is dropped outright, so no squash is needed.
        if (branch_taken_i) begin
          w_redirect = 1'b1;
          if (imem_rsp_valid_i) begin
            w_squash_d = 1'b0;
            w_state_d  = REQ;
          end else begin
            w_squash_d = 1'b1;
          end
        end else if (imem_rsp_valid_i) begin
          if (r_squash) begin
            w_squash_d = 1'b0;
            w_state_d  = REQ;
          end else begin
            w_capture = 1'b1;
            w_incr    = 1'b1;
            w_valid_d = 1'b1;
            w_state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken_i) begin
          w_redirect = 1'b1;
          w_valid_d  = 1'b0;
          w_state_d  = REQ;
        end else if (instr_ready_i) begin
          w_valid_d = 1'b0;
          w_state_d = REQ;
        end
      end
      default: w_state_d = RST;
    endcase
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = w_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a latency-programmable imem model
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        branch_taken = 1'b0;
  logic [18:0] branch_target = '0;
  logic        imem_req;
  logic [18:0] imem_addr;
  logic        rsp_valid = 1'b0;
  logic [18:0] rsp_data = '0;
  logic        instr_valid;
  logic [18:0] instr;
  logic [18:0] instr_pc;
  logic        instr_ready = 1'b1;

  logic        branch2 = 1'b0;
  logic [18:0] target2 = '0;
  logic        imem_req2;
  logic [18:0] imem_addr2;
  logic        rsp2_valid = 1'b0;
  logic [18:0] rsp2_data = '0;
  logic        instr_valid2;
  logic [18:0] instr2;
  logic [18:0] instr_pc2;
  logic        ready2 = 1'b1;

  int checks = 0;
  int failures = 0;

  int          mem_lat = 1;
  int          pend_cnt = 0;
  logic        pend = 1'b0;
  logic [18:0] pend_addr = '0;
  logic        req2_prev = 1'b0;
  logic [18:0] addr2_prev = '0;

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n),
    .branch_taken_i(branch_taken), .branch_target_i(branch_target),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(instr_ready)
  );

  instr_fetch #(.RESET_PC(19'h7FFFF)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .branch_taken_i(branch2), .branch_target_i(target2),
    .imem_req_o(imem_req2), .imem_addr_o(imem_addr2),
    .imem_rsp_valid_i(rsp2_valid), .imem_rsp_data_i(rsp2_data),
    .instr_valid_o(instr_valid2), .instr_o(instr2), .instr_pc_o(instr_pc2),
    .instr_ready_i(ready2)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] data_of(input logic [18:0] a);
    case (a)
      19'h00000: return 19'h12345;
      19'h00001: return 19'h00ABC;
      default:   return a ^ 19'h2AAAA;
    endcase
  endfunction

  // Memory model: a request seen in cycle k is answered for one cycle in cycle k+mem_lat.
  always @(negedge clk) begin
    rsp_valid = 1'b0;
    if (pend) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = data_of(pend_addr);
        pend      = 1'b0;
      end
    end
    if (reset_n && imem_req) begin
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = imem_addr;
    end
    rsp2_valid = req2_prev;
    rsp2_data  = addr2_prev ^ 19'h15555;
    req2_prev  = imem_req2;
    addr2_prev = imem_addr2;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    branch_taken = 1'b0;
    instr_ready = 1'b1;
    mem_lat = 1;
    pend = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    checks++; if (imem_addr !== 19'h00000) begin failures++; $display("FAIL rst_addr got=%h exp=00000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", instr_valid); end
    checks++; if (instr !== 19'h0 || instr_pc !== 19'h0) begin failures++; $display("FAIL rst_instr got=%h/%h exp=0/0", instr, instr_pc); end
    checks++; if (imem_addr2 !== 19'h7FFFF) begin failures++; $display("FAIL rst_addr2 got=%h exp=7ffff", imem_addr2); end
    reset_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_state_req got=%h exp=0", imem_req); end
  endtask

  task automatic test_basic();
    int nreq = 0;
    int ndel = 0;
    int rc[2];
    logic [18:0] ra[2];
    logic [18:0] dp[2];
    logic [18:0] di[2];
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (imem_req && nreq < 2) begin ra[nreq] = imem_addr; rc[nreq] = c; nreq++; end
      if (instr_valid && instr_ready && ndel < 2) begin dp[ndel] = instr_pc; di[ndel] = instr; ndel++; end
    end
    checks++; if (nreq != 2 || ndel != 2) begin failures++; $display("FAIL basic_counts got=%0d/%0d exp=2/2", nreq, ndel); end
    checks++; if (ra[0] !== 19'h0 || ra[1] !== 19'h1) begin failures++; $display("FAIL basic_req_addr got=%h,%h exp=0,1", ra[0], ra[1]); end
    checks++; if (rc[0] != 1 || rc[1] != 4) begin failures++; $display("FAIL basic_req_cycle got=%0d,%0d exp=1,4", rc[0], rc[1]); end
    checks++; if (dp[0] !== 19'h0 || di[0] !== 19'h12345) begin failures++; $display("FAIL basic_del0 got=%h/%h exp=0/12345", dp[0], di[0]); end
    checks++; if (dp[1] !== 19'h1 || di[1] !== 19'h00ABC) begin failures++; $display("FAIL basic_del1 got=%h/%h exp=1/00abc", dp[1], di[1]); end
  endtask

  task automatic test_stall();
    int n = 0;
    int bad = 0;
    do_reset();
    instr_ready = 1'b0;
    do begin tick(); n++; end while (!instr_valid && n < 10);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 19'h0 || instr !== 19'h12345) begin failures++; $display("FAIL stall_first got=%h/%h/%h exp=1/0/12345", instr_valid, instr_pc, instr); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr_valid !== 1'b1 || instr !== 19'h12345 || instr_pc !== 19'h0 || imem_req !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    instr_ready = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 19'h1 || instr_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=%h/%h/%h exp=1/00001/0", imem_req, imem_addr, instr_valid); end
  endtask

  task automatic test_branch_wait();
    int n = 0;
    do_reset();
    mem_lat = 3;
    tick();
    tick();
    branch_taken = 1'b1; branch_target = 19'h00400;
    tick();
    branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 19'h00400) begin failures++; $display("FAIL bw_redirect got=%h/%h exp=0/00400", imem_req, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bw_rsp_cycle got=%h exp=0", instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 19'h00400 || instr_valid !== 1'b0) begin failures++; $display("FAIL bw_refetch got=%h/%h/%h exp=1/00400/0", imem_req, imem_addr, instr_valid); end
    do begin tick(); n++; end while (!instr_valid && n < 10);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 19'h00400 || instr !== 19'h2AEAA) begin failures++; $display("FAIL bw_target_del got=%h/%h/%h exp=1/00400/2aeaa", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_branch_coincident();
    int n = 0;
    do_reset();
    tick();
    tick();
    branch_taken = 1'b1; branch_target = 19'h00123;
    tick();
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 19'h00123) begin failures++; $display("FAIL bc_wait got=%h/%h/%h exp=0/1/00123", instr_valid, imem_req, imem_addr); end
    do begin tick(); n++; end while (!instr_valid && n < 10);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 19'h00123 || instr !== 19'h2AB89) begin failures++; $display("FAIL bc_target_del got=%h/%h/%h exp=1/00123/2ab89", instr_valid, instr_pc, instr); end
    branch_taken = 1'b1; branch_target = 19'h00200;
    tick();
    branch_taken = 1'b0;
    instr_ready = 1'b1;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 19'h00200) begin failures++; $display("FAIL bc_hold got=%h/%h/%h exp=0/1/00200", instr_valid, imem_req, imem_addr); end
    n = 0;
    do begin tick(); n++; end while (!instr_valid && n < 10);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 19'h00200 || instr !== 19'h2A8AA) begin failures++; $display("FAIL bc_hold_del got=%h/%h/%h exp=1/00200/2a8aa", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_wrap();
    int nreq = 0;
    logic        got = 1'b0;
    logic [18:0] ra[2];
    logic [18:0] dp = '0;
    logic [18:0] di = '0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (imem_req2 && nreq < 2) begin ra[nreq] = imem_addr2; nreq++; end
      if (instr_valid2 && !got) begin got = 1'b1; dp = instr_pc2; di = instr2; end
    end
    checks++; if (nreq != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", nreq); end
    checks++; if (ra[0] !== 19'h7FFFF) begin failures++; $display("FAIL wrap_first got=%h exp=7ffff", ra[0]); end
    checks++; if (ra[1] !== 19'h00000) begin failures++; $display("FAIL wrap_second got=%h exp=00000", ra[1]); end
    checks++; if (!got || dp !== 19'h7FFFF || di !== 19'h6AAAA) begin failures++; $display("FAIL wrap_del got=%h/%h exp=7ffff/6aaaa", dp, di); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bad = 0;
    do_reset();
    tick();
    tick();
    tick();
    mem_lat = 4;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 19'h1) begin failures++; $display("FAIL rm_req1 got=%h/%h exp=1/00001", imem_req, imem_addr); end
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 19'h0 || instr_valid !== 1'b0 || instr !== 19'h0 || instr_pc !== 19'h0) begin failures++; $display("FAIL rm_async got=%h/%h/%h/%h/%h exp=0/0/0/0/0", imem_req, imem_addr, instr_valid, instr, instr_pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (imem_req !== 1'b0 || imem_addr !== 19'h0 || instr_valid !== 1'b0 || instr !== 19'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rm_late_rsp got=%0d bad cycles exp=0", bad); end
    mem_lat = 1;
    reset_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 19'h0) begin failures++; $display("FAIL rm_restart got=%h/%h exp=1/00000", imem_req, imem_addr); end
    do begin tick(); n++; end while (!instr_valid && n < 10);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 19'h0 || instr !== 19'h12345) begin failures++; $display("FAIL rm_del got=%h/%h/%h exp=1/00000/12345", instr_valid, instr_pc, instr); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_branch_wait();
    test_branch_coincident();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
